// File: rtl/lsu_csr_lane_sequencer_if.sv
// ---------------------------------------------------------------------------
// lsu_csr_lane_sequencer_if
//
// Bundles the three channels around the LSU-to-CSR lane sequencer:
//   req_*  : one multi-lane CSR access from the LSU issue path (valid/ready)
//   csr_*  : single 32-bit CSR read/write port, one lane per cycle
//   rsp_*  : tagged response towards LSU writeback (valid/ready)
//
// Modports:
//   master : the sequencer. It consumes requests, drives the CSR strobes and
//            produces responses.
//   slave  : the surroundings. They offer requests, model the CSR file and
//            consume responses.
//
// Lane i of a packed per-lane bus sits at [i*W +: W].
// ---------------------------------------------------------------------------
interface lsu_csr_lane_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_BITS = 12,
  parameter int TAG_WIDTH = 8
);
  // request channel
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_rw;
  logic [NUM_LANES-1:0]           req_mask;
  logic [NUM_LANES*ADDR_BITS-1:0] req_addr;
  logic [NUM_LANES*32-1:0]        req_data;
  logic [TAG_WIDTH-1:0]           req_tag;

  // CSR channel
  logic                           csr_write_enable;
  logic [ADDR_BITS-1:0]           csr_write_addr;
  logic [31:0]                    csr_write_data;
  logic                           csr_read_enable;
  logic [ADDR_BITS-1:0]           csr_read_addr;
  logic [31:0]                    csr_read_data;

  // response channel
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic                           rsp_rw;
  logic [NUM_LANES-1:0]           rsp_mask;
  logic [NUM_LANES*32-1:0]        rsp_data;
  logic [TAG_WIDTH-1:0]           rsp_tag;

  modport master (
    input  req_valid, req_rw, req_mask, req_addr, req_data, req_tag,
    output req_ready,
    output csr_write_enable, csr_write_addr, csr_write_data,
    output csr_read_enable, csr_read_addr,
    input  csr_read_data,
    output rsp_valid, rsp_rw, rsp_mask, rsp_data, rsp_tag,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_rw, req_mask, req_addr, req_data, req_tag,
    input  req_ready,
    input  csr_write_enable, csr_write_addr, csr_write_data,
    input  csr_read_enable, csr_read_addr,
    output csr_read_data,
    input  rsp_valid, rsp_rw, rsp_mask, rsp_data, rsp_tag,
    output rsp_ready
  );
endinterface

// File: rtl/lsu_csr_lane_sequencer.sv
// ---------------------------------------------------------------------------
// lsu_csr_lane_sequencer
//
// Takes one multi-lane CSR access from the LSU, issues its active lanes one
// per cycle (ascending lane order) on the single CSR read/write port, gathers
// read data back into a lane vector and returns one tagged response.
//
// Ports:
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : lsu_csr_lane_sequencer_if.master (req_*, csr_*, rsp_*)
//
// Timing, request accepted at cycle T with k active lanes:
//   strobes at T+1..T+k; write response at T+k+1; read response at T+k+2
//   (the extra cycle captures the final read word); empty mask -> T+1.
// ---------------------------------------------------------------------------
module lsu_csr_lane_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int ADDR_BITS = 12,
  parameter int TAG_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  lsu_csr_lane_sequencer_if.master  bus
);

  localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t                         state_reg;
  logic [NUM_LANES-1:0]           pending_reg;
  logic [NUM_LANES*ADDR_BITS-1:0] addr_buf_reg;
  logic [NUM_LANES*32-1:0]        data_buf_reg;
  logic                           rw_reg;
  logic [NUM_LANES-1:0]           mask_reg;
  logic [TAG_WIDTH-1:0]           tag_reg;
  logic [NUM_LANES*32-1:0]        rsp_data_reg;
  logic [LANE_BITS-1:0]           lane_reg;

  logic                           write_enable_reg;
  logic [ADDR_BITS-1:0]           write_addr_reg;
  logic [31:0]                    write_data_reg;
  logic                           read_enable_reg;
  logic [ADDR_BITS-1:0]           read_addr_reg;

  // High on the cycle after a read strobe, when csr_read_data is valid.
  logic                           capture_reg;
  logic [LANE_BITS-1:0]           capture_lane_reg;

  // Lane selection source: the live request while IDLE (so the first strobe
  // leaves on the cycle right after accept), the latched copy afterwards.
  logic                           idle;
  logic [NUM_LANES-1:0]           src_mask;
  logic [NUM_LANES*ADDR_BITS-1:0] src_addr;
  logic [NUM_LANES*32-1:0]        src_data;
  logic                           src_rw;

  logic                           sel_found;
  logic [LANE_BITS-1:0]           sel_lane;
  logic [NUM_LANES-1:0]           sel_onehot;
  logic [ADDR_BITS-1:0]           sel_addr;
  logic [31:0]                    sel_data;
  logic                           issue;
  logic [NUM_LANES-1:0]           capture_hit;

  assign idle     = (state_reg == IDLE);
  assign src_mask = idle ? bus.req_mask : pending_reg;
  assign src_addr = idle ? bus.req_addr : addr_buf_reg;
  assign src_data = idle ? bus.req_data : data_buf_reg;
  assign src_rw   = idle ? bus.req_rw   : rw_reg;

  // Priority encoder: scanning downwards leaves the lowest set lane selected.
  always_comb begin
    sel_found  = 1'b0;
    sel_lane   = '0;
    sel_onehot = '0;
    sel_addr   = '0;
    sel_data   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        sel_found  = 1'b1;
        sel_lane   = LANE_BITS'(i);
        sel_onehot = NUM_LANES'(1) << i;
        sel_addr   = src_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_data   = src_data[i*32 +: 32];
      end
    end
  end

  // A strobe is launched on accept (first lane) and on every ACCESS cycle
  // that still has a pending lane; inactive lanes therefore cost nothing.
  assign issue = sel_found && ((idle && bus.req_valid) || (state_reg == ACCESS));

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_capture
      assign capture_hit[gi] = capture_reg && (capture_lane_reg == LANE_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      pending_reg      <= '0;
      addr_buf_reg     <= '0;
      data_buf_reg     <= '0;
      rw_reg           <= 1'b0;
      mask_reg         <= '0;
      tag_reg          <= '0;
      rsp_data_reg     <= '0;
      lane_reg         <= '0;
      write_enable_reg <= 1'b0;
      write_addr_reg   <= '0;
      write_data_reg   <= '0;
      read_enable_reg  <= 1'b0;
      read_addr_reg    <= '0;
      capture_reg      <= 1'b0;
      capture_lane_reg <= '0;
    end else begin
      // Strobes are single-cycle; address/data return to 0 with them.
      write_enable_reg <= 1'b0;
      write_addr_reg   <= '0;
      write_data_reg   <= '0;
      read_enable_reg  <= 1'b0;
      read_addr_reg    <= '0;

      capture_reg      <= read_enable_reg;
      capture_lane_reg <= lane_reg;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (capture_hit[i]) begin
          rsp_data_reg[i*32 +: 32] <= bus.csr_read_data;
        end
      end

      if (issue) begin
        pending_reg <= src_mask & ~sel_onehot;
        lane_reg    <= sel_lane;
        if (src_rw) begin
          write_enable_reg <= 1'b1;
          write_addr_reg   <= sel_addr;
          write_data_reg   <= sel_data;
        end else begin
          read_enable_reg  <= 1'b1;
          read_addr_reg    <= sel_addr;
        end
      end

      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            rw_reg       <= bus.req_rw;
            mask_reg     <= bus.req_mask;
            tag_reg      <= bus.req_tag;
            addr_buf_reg <= bus.req_addr;
            data_buf_reg <= bus.req_data;
            rsp_data_reg <= '0;
            state_reg    <= sel_found ? ACCESS : RESP;
          end
        end
        ACCESS: begin
          // Nothing left to issue: the last strobe went out last cycle.
          if (!sel_found) begin
            state_reg <= rw_reg ? RESP : DRAIN;
          end
        end
        DRAIN: begin
          state_reg <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready        = idle;
  assign bus.rsp_valid        = (state_reg == RESP);
  assign bus.rsp_rw           = rw_reg;
  assign bus.rsp_mask         = mask_reg;
  assign bus.rsp_tag          = tag_reg;
  assign bus.rsp_data         = rsp_data_reg;
  assign bus.csr_write_enable = write_enable_reg;
  assign bus.csr_write_addr   = write_addr_reg;
  assign bus.csr_write_data   = write_data_reg;
  assign bus.csr_read_enable  = read_enable_reg;
  assign bus.csr_read_addr    = read_addr_reg;

endmodule

// File: tb/tb_lsu_csr_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lsu_csr_lane_sequencer
//
// Drives multi-lane CSR requests into lsu_csr_lane_sequencer, models a CSR
// file that answers reads with addr+0x1000 one cycle later, and checks the
// strobe sequence and responses against expectations queued at drive time.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_csr_lane_sequencer;

  localparam int NL = 4;
  localparam int AB = 12;
  localparam int TW = 8;

  logic clk;
  logic reset_n;

  lsu_csr_lane_sequencer_if #(.NUM_LANES(NL), .ADDR_BITS(AB), .TAG_WIDTH(TW)) bus_if ();

  lsu_csr_lane_sequencer #(.NUM_LANES(NL), .ADDR_BITS(AB), .TAG_WIDTH(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR model: read data appears exactly one cycle after the strobe; any
  // other cycle carries a poison word so mistimed captures show up.
  always @(posedge clk) begin
    if (bus_if.csr_read_enable)
      bus_if.csr_read_data <= 32'(bus_if.csr_read_addr) + 32'h1000;
    else
      bus_if.csr_read_data <= 32'hDEAD_BEEF;
  end

  typedef struct {
    bit          rw;
    logic [AB-1:0] addr;
    logic [31:0] data;
    int          off;
  } strobe_t;

  typedef struct {
    bit             rw;
    logic [NL-1:0]  mask;
    logic [NL*32-1:0] data;
    logic [TW-1:0]  tag;
    int             lat;
  } rsp_t;

  strobe_t strobe_q[$];
  rsp_t    rsp_q[$];
  int      accept_q[$];

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int last_t = 0;
  bit prev_valid = 0;
  bit expect_ready = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid   = 0;
      expect_ready = 0;
    end else begin
      ncyc++;
      if (bus_if.req_valid && bus_if.req_ready) begin
        last_t = ncyc;
        accept_q.push_back(ncyc);
      end

      check_eq("strobe_exclusive", {127'd0, bus_if.csr_write_enable && bus_if.csr_read_enable}, 128'd0);
      if (bus_if.csr_write_enable || bus_if.csr_read_enable) begin
        if (strobe_q.size() == 0) begin
          check_eq("strobe_unexpected", 128'd1, 128'd0);
        end else begin
          strobe_t e;
          e = strobe_q.pop_front();
          check_eq("strobe_rw", {127'd0, bus_if.csr_write_enable}, {127'd0, e.rw});
          check_eq("strobe_addr",
                   bus_if.csr_write_enable ? 128'(bus_if.csr_write_addr) : 128'(bus_if.csr_read_addr),
                   128'(e.addr));
          check_eq("strobe_data", 128'(bus_if.csr_write_data), 128'(e.data));
          check_eq("strobe_cycle", 128'(ncyc - last_t), 128'(e.off));
        end
      end
      if (!bus_if.csr_write_enable)
        check_eq("wr_bus_idle", {84'd0, bus_if.csr_write_addr, bus_if.csr_write_data}, 128'd0);
      if (!bus_if.csr_read_enable)
        check_eq("rd_bus_idle", 128'(bus_if.csr_read_addr), 128'd0);

      if (expect_ready) begin
        check_eq("b2b_req_ready", {127'd0, bus_if.req_ready}, 128'd1);
        expect_ready = 0;
      end

      if (bus_if.rsp_valid) begin
        check_eq("rsp_req_ready_low", {127'd0, bus_if.req_ready}, 128'd0);
        if (rsp_q.size() == 0 || accept_q.size() == 0) begin
          check_eq("rsp_unexpected", 128'd1, 128'd0);
        end else begin
          rsp_t r;
          r = rsp_q[0];
          if (!prev_valid)
            check_eq("rsp_latency", 128'(ncyc - accept_q[0]), 128'(r.lat));
          check_eq("rsp_rw", {127'd0, bus_if.rsp_rw}, {127'd0, r.rw});
          check_eq("rsp_mask", 128'(bus_if.rsp_mask), 128'(r.mask));
          check_eq("rsp_tag", 128'(bus_if.rsp_tag), 128'(r.tag));
          check_eq("rsp_data", bus_if.rsp_data, r.data);
          if (bus_if.rsp_ready) begin
            $display("rsp tag=%02h rw=%0d mask=%b data=%032h cycle=%0d",
                     bus_if.rsp_tag, bus_if.rsp_rw, bus_if.rsp_mask, bus_if.rsp_data, ncyc);
            void'(rsp_q.pop_front());
            void'(accept_q.pop_front());
            expect_ready = 1;
          end
        end
      end
      prev_valid = bus_if.rsp_valid;
    end
  end

  // Queue expectations, present the request and hold it until accepted.
  // Called shortly after a rising edge.
  task automatic send(input bit rw, input logic [NL-1:0] mask, input logic [NL*AB-1:0] addr,
                      input logic [NL*32-1:0] data, input logic [TW-1:0] tag);
    rsp_t r;
    int   k;
    bit   accepted;
    k = 0;
    r.rw = rw; r.mask = mask; r.tag = tag; r.data = '0;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        strobe_t s;
        k++;
        s.rw   = rw;
        s.addr = addr[i*AB +: AB];
        s.data = rw ? data[i*32 +: 32] : 32'd0;
        s.off  = k;
        strobe_q.push_back(s);
        if (!rw) r.data[i*32 +: 32] = 32'(addr[i*AB +: AB]) + 32'h1000;
      end
    end
    r.lat = (k == 0) ? 1 : (rw ? k + 1 : k + 2);
    rsp_q.push_back(r);

    bus_if.req_valid = 1'b1;
    bus_if.req_rw    = rw;
    bus_if.req_mask  = mask;
    bus_if.req_addr  = addr;
    bus_if.req_data  = data;
    bus_if.req_tag   = tag;
    accepted = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (bus_if.req_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) check_eq("req_accept_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    // Scramble the request lines: they must not matter after accept.
    bus_if.req_valid = 1'b0;
    bus_if.req_rw    = 1'($urandom);
    bus_if.req_mask  = NL'($urandom);
    bus_if.req_addr  = {$urandom, $urandom};
    bus_if.req_data  = {$urandom, $urandom, $urandom, $urandom};
    bus_if.req_tag   = TW'($urandom);
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rsp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) check_eq("rsp_timeout", 128'd0, 128'd1);
    if (strobe_q.size() != 0) check_eq("strobes_left", 128'(strobe_q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_rw    = 1'b0;
    bus_if.req_mask  = '0;
    bus_if.req_addr  = '0;
    bus_if.req_data  = '0;
    bus_if.req_tag   = '0;
    bus_if.rsp_ready = 1'b1;

    #2;
    check_eq("rst_req_ready", {127'd0, bus_if.req_ready}, 128'd1);
    check_eq("rst_rsp_valid", {127'd0, bus_if.rsp_valid}, 128'd0);
    check_eq("rst_strobes", {126'd0, bus_if.csr_write_enable, bus_if.csr_read_enable}, 128'd0);
    check_eq("rst_csr_bus", {72'd0, bus_if.csr_write_addr, bus_if.csr_write_data, bus_if.csr_read_addr}, 128'd0);
    check_eq("rst_rsp_data", bus_if.rsp_data, 128'd0);
    check_eq("rst_rsp_fields", {115'd0, bus_if.rsp_rw, bus_if.rsp_mask, bus_if.rsp_tag}, 128'd0);
    #20 reset_n = 1'b1;

    // 1. write, lane 2 skipped
    @(posedge clk); #1;
    send(1'b1, 4'b1011, {12'h303, 12'h302, 12'h301, 12'h300},
         {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000}, 8'h11);
    wait_done();

    // 2. full read
    send(1'b0, 4'b1111, {12'h313, 12'h312, 12'h311, 12'h310}, '0, 8'h22);
    wait_done();

    // 3. single-lane read
    send(1'b0, 4'b0100, {12'h7FF, 12'hC00, 12'h123, 12'h456}, '0, 8'h33);
    wait_done();

    // 4. empty mask
    send(1'b0, 4'b0000, {12'h001, 12'h002, 12'h003, 12'h004}, '0, 8'h5A);
    wait_done();

    // 5. response held off, then back-to-back request
    bus_if.rsp_ready = 1'b0;
    send(1'b0, 4'b1111, {12'hF03, 12'hF02, 12'hF01, 12'hF00}, '0, 8'h44);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (bus_if.rsp_valid) break;
    end
    check_eq("hold_rsp_seen", {127'd0, bus_if.rsp_valid}, 128'd1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b1;
    send(1'b1, 4'b0110, {12'h343, 12'h342, 12'h341, 12'h340},
         {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 8'h55);
    wait_done();

    // 6. reset in the middle of a 4-lane read
    send(1'b0, 4'b1111, {12'h383, 12'h382, 12'h381, 12'h380}, '0, 8'h66);
    @(negedge clk);          // lane 0 strobe cycle
    @(negedge clk); #2;      // lane 1 strobe cycle
    check_eq("mid_read_strobe", {127'd0, bus_if.csr_read_enable}, 128'd1);
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_strobes", {126'd0, bus_if.csr_write_enable, bus_if.csr_read_enable}, 128'd0);
    check_eq("async_rst_rsp_valid", {127'd0, bus_if.rsp_valid}, 128'd0);
    strobe_q.delete();
    rsp_q.delete();
    accept_q.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check_eq("post_rst_no_rsp", {127'd0, bus_if.rsp_valid}, 128'd0);
      check_eq("post_rst_req_ready", {127'd0, bus_if.req_ready}, 128'd1);
    end
    @(posedge clk); #1;
    send(1'b1, 4'b1001, {12'h3A3, 12'h3A2, 12'h3A1, 12'h3A0},
         {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8'h77);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_csr_lane_sequencer.md
# lsu_csr_lane_sequencer

LSU-side master for the LSU-to-CSR port. It accepts one multi-lane CSR access from the LSU issue path and serializes the active lanes onto the single 32-bit CSR read/write channel, one lane per cycle. For reads, it gathers the returned words back into a lane vector. It then presents a single tagged response to the LSU writeback path through a valid/ready handshake.

## Interface
- NUM_LANES, 4, lanes per request (matches `NUM_LSU_LANES`)
- ADDR_BITS, 12, CSR address width (matches `VX_CSR_ADDR_BITS`)
- TAG_WIDTH, 8, opaque request tag width
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high with req_valid
- req_rw  in  1  1 = write, 0 = read
- req_mask  in  NUM_LANES  active lanes
- req_addr  in  NUM_LANES×ADDR_BITS  per-lane CSR address
- req_data  in  NUM_LANES×32  per-lane write data
- req_tag  in  TAG_WIDTH  tag
- csr_write_enable  out  1  CSR write strobe
- csr_write_addr  out  ADDR_BITS  write address
- csr_write_data  out  32  write data
- csr_read_enable  out  1  CSR read strobe
- csr_read_addr  out  ADDR_BITS  read address
- csr_read_data  in  32  read data, valid exactly one cycle after csr_read_enable
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rw  out  1  echo of req_rw
- rsp_mask  out  NUM_LANES  echo of req_mask
- rsp_data  out  NUM_LANES×32  gathered read data
- rsp_tag  out  TAG_WIDTH  echo of req_tag

## Operation
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake, latch rw, mask, addr, data and tag, and clear the rsp_data buffer.
  - mask == 0 → RESP. Otherwise → ACCESS, with the lane pointer at the lowest set bit.
- ACCESS:
  - Each cycle, drive one strobe (write_enable if rw, else read_enable) with the current lane's address and data.
  - Clear that lane from the pending mask, and move the pointer to the next set bit using a priority encoder. Inactive lanes cost zero cycles.
  - When the last pending lane issues: write → RESP; read → DRAIN.
- Read capture:
  - A registered flag marks the cycle after any read strobe, and a registered lane index records which lane was read.
  - On that cycle, csr_read_data is written into rsp_data[index].
  - Capture happens in ACCESS (for the previous lane) and in DRAIN (for the final lane).
- DRAIN: captures the final read word → RESP.
- RESP:
  - rsp_valid = 1, with all rsp_* fields stable until rsp_ready.
  - On handshake → IDLE.
  - No new request is accepted before the response is consumed, so req_ready = 0 outside IDLE.
- Response data rules:
  - Inactive lanes in rsp_data are 0.
  - For writes, rsp_data is all 0.
- Strobe rules:
  - csr_write_enable and csr_read_enable are never high together.
  - The csr addr and data outputs are 0 whenever their strobe is low.
- Lanes issue in ascending index order.

## Timing
- Reset values:
  - State is IDLE, so req_ready = 1.
  - Low: rsp_valid, both strobes, all csr addr/data outputs, rsp_data, rsp_mask, rsp_tag and rsp_rw.
- Request accepted at cycle T with k active lanes:
  - Strobes occur at T+1 … T+k.
  - Write: rsp_valid at T+k+1.
  - Read: captures at T+2 … T+k+1; rsp_valid at T+k+2.
  - mask == 0: no strobes; rsp_valid at T+1.
- Back-to-back: when rsp_ready is high on the first rsp_valid cycle R, req_ready is high at R+1.
- rsp_ready held low: the response holds indefinitely and no CSR strobes are issued.
- Reset mid-operation:
  - Strobes and rsp_valid drop immediately (asynchronous).
  - The pending request is discarded with no partial response.
  - The block returns to IDLE.
- Inputs are sampled only at the request handshake. Later changes on req_* have no effect.

## Test plan
- Write with mask 4'b1011, addr {0x300,0x301,0x302,0x303}, data {A0,A1,A2,A3}:
  - Write strobes on 3 consecutive cycles, in order (0x300,A0), (0x301,A1), (0x303,A3).
  - rsp_valid 4 cycles after accept, with rsp_data all 0.
- Read with mask 4'b1111, where the CSR model returns addr+0x1000 one cycle after each read:
  - rsp_data = {addr0+0x1000 … addr3+0x1000}.
  - rsp_valid at T+6.
  - rsp_tag and rsp_mask are echoed.
- Read with mask 4'b0100:
  - Exactly one read strobe, at lane 2's address.
  - rsp_data lanes 0, 1 and 3 are 0.
  - rsp_valid at T+3.
- mask 4'b0000:
  - No strobes.
  - rsp_valid at T+1 with the tag echoed.
- rsp_ready held low for 5 cycles, then pulsed:
  - Response fields remain stable throughout, and req_ready stays 0.
  - req_ready = 1 on the cycle after the handshake, and a back-to-back second request is serviced correctly.
- reset_n asserted during the second lane of a 4-lane read:
  - Strobes drop in the same cycle, and no rsp_valid appears.
  - After release, req_ready = 1 and a fresh write completes normally.
